// File: rtl/rem_stream_tx.sv
// rem_stream_tx: MSB-first serial transmitter with a running residue (din mod DIV).
// A word is taken through a load/ready handshake, driven one bit per clock on
// x_out/x_valid, and followed by a single DONE cycle that pulses done and
// publishes the residue of the completed word on rem_out.
module rem_stream_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 3,
  parameter int unsigned REM_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic [REM_W-1:0] rem_out
);

  // Counter holds the number of bits still to be driven after the current one.
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [REM_W:0] DIV_V = (REM_W + 1)'(DIV);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] res;

  // One residue step: (2*r + b) mod DIV. Since r < DIV, 2*r + b < 2*DIV, so one
  // conditional subtract in an REM_W+1-bit intermediate is enough.
  function automatic logic [REM_W-1:0] next_res(input logic [REM_W-1:0] r,
                                                input logic             b);
    logic [REM_W:0] t;
    t = {r, b};
    if (t >= DIV_V) begin
      t = t - DIV_V;
    end
    return t[REM_W-1:0];
  endfunction

  // Frame FSM with registered outputs. Outputs are computed from the state being
  // entered, so the MSB is on x_out in the cycle right after the accepting edge
  // and a load held through DONE starts the next frame with a single bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      rem_out <= '0;
      shift_q <= '0;
      cnt     <= '0;
      res     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          ready   <= 1'b1;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          state   <= IDLE;
          if (load) begin
            // Drive the MSB now; the residue starts from zero folded with it.
            shift_q <= din << 1;
            x_out   <= din[WIDTH-1];
            x_valid <= 1'b1;
            ready   <= 1'b0;
            cnt     <= CNT_W'(WIDTH - 1);
            res     <= next_res('0, din[WIDTH-1]);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            x_out   <= shift_q[WIDTH-1];
            shift_q <= shift_q << 1;
            cnt     <= cnt - CNT_W'(1);
            res     <= next_res(res, shift_q[WIDTH-1]);
          end else begin
            // Last bit has been on the line; close the frame.
            state   <= DONE;
            done    <= 1'b1;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            ready   <= 1'b1;
            rem_out <= res;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rem_stream_tx.sv
// Directed bench for rem_stream_tx: main instance (WIDTH=8, DIV=3) plus a
// DIV=5 variant and a WIDTH=1 variant. Expected residues are hand-computed.
module tb_rem_stream_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       ready, x_out, x_valid, done;
  logic [1:0] rem_out;

  logic       load5;
  logic [7:0] din5;
  logic       ready5, x_out5, x_valid5, done5;
  logic [2:0] rem_out5;

  logic       load1;
  logic [0:0] din1;
  logic       ready1, x_out1, x_valid1, done1;
  logic [1:0] rem_out1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rem_stream_tx #(.WIDTH(8), .DIV(3), .REM_W(2)) u_dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .ready(ready),
    .x_out(x_out), .x_valid(x_valid), .done(done), .rem_out(rem_out)
  );

  rem_stream_tx #(.WIDTH(8), .DIV(5), .REM_W(3)) u_div5 (
    .clk(clk), .rst(rst), .load(load5), .din(din5), .ready(ready5),
    .x_out(x_out5), .x_valid(x_valid5), .done(done5), .rem_out(rem_out5)
  );

  rem_stream_tx #(.WIDTH(1), .DIV(3), .REM_W(2)) u_w1 (
    .clk(clk), .rst(rst), .load(load1), .din(din1), .ready(ready1),
    .x_out(x_out1), .x_valid(x_valid1), .done(done1), .rem_out(rem_out1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the eight bits of a frame already accepted; leaves the bench in the done cycle.
  task automatic check_bits(input string tag, input logic [7:0] word);
    for (int k = 0; k < 8; k++) begin
      check({tag, "_valid"}, x_valid, 1'b1);
      check({tag, "_bit"},   x_out,   word[7-k]);
      check({tag, "_ready"}, ready,   1'b0);
      check({tag, "_nodone"}, done,   1'b0);
      step();
    end
  endtask

  task automatic check_done(input string tag, input logic [1:0] exp_rem);
    check({tag, "_done"},   done,    1'b1);
    check({tag, "_dready"}, ready,   1'b1);
    check({tag, "_dvalid"}, x_valid, 1'b0);
    check({tag, "_dxout"},  x_out,   1'b0);
    check({tag, "_rem"},    rem_out, exp_rem);
  endtask

  // Full frame: accept, eight bits, done, then one idle cycle with rem_out held.
  task automatic send_frame(input string tag, input logic [7:0] word, input logic [1:0] exp_rem);
    load = 1'b1;
    din  = word;
    step();
    load = 1'b0;
    din  = 8'h00;
    check_bits(tag, word);
    check_done(tag, exp_rem);
    step();
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_rem"},  rem_out, exp_rem);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    din   = 8'h00;
    load5 = 1'b0;
    din5  = 8'h00;
    load1 = 1'b0;
    din1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   ready,   1'b1);
    check("rst_x_out",   x_out,   1'b0);
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_rem",     rem_out, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 0xB5 = 181, 181 mod 3 = 1; accepted on the first edge after reset release.
    send_frame("b5", 8'hB5, 2'd1);

    // 2: 255 mod 3 = 0, 2 mod 3 = 2, 0 mod 3 = 0.
    send_frame("ff", 8'hFF, 2'd0);
    send_frame("02", 8'h02, 2'd2);
    send_frame("00", 8'h00, 2'd0);

    // 3: back-to-back 0x07 (rem 1) then 0x05 (rem 2); load stays high through DONE.
    load = 1'b1;
    din  = 8'h07;
    step();
    din  = 8'h05;
    check_bits("b2b_a", 8'h07);
    check_done("b2b_a", 2'd1);
    step();
    load = 1'b0;
    din  = 8'h00;
    check("b2b_first_bit_valid", x_valid, 1'b1);
    check("b2b_rem_hold", rem_out, 2'd1);
    for (int k = 0; k < 8; k++) begin
      check("b2b_b_bit", x_out, 8'h05 >> (7 - k) & 8'h01);
      check("b2b_b_valid", x_valid, 1'b1);
      step();
    end
    check_done("b2b_b", 2'd2);
    step();

    // 4: 0x0F = 15, rem 0; a load of 0xAA in cycle 3 must be ignored.
    load = 1'b1;
    din  = 8'h0F;
    step();
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        load = 1'b1;
        din  = 8'hAA;
      end else begin
        load = 1'b0;
        din  = 8'h00;
      end
      check("ign_bit",   x_out,   8'h0F >> (7 - k) & 8'h01);
      check("ign_valid", x_valid, 1'b1);
      check("ign_ready", ready,   1'b0);
      step();
    end
    load = 1'b0;
    check_done("ign", 2'd0);
    step();
    check("ign_back_idle", x_valid, 1'b0);

    // 5: reset in cycle 4 of a 0xB5 frame; outputs clear asynchronously.
    load = 1'b1;
    din  = 8'hB5;
    step();
    load = 1'b0;
    step();
    step();
    step();
    check("abort_pre_valid", x_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_valid", x_valid, 1'b0);
    check("abort_xout",  x_out,   1'b0);
    check("abort_done",  done,    1'b0);
    check("abort_rem",   rem_out, 2'd0);
    check("abort_ready", ready,   1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("abort_no_done", done, 1'b0);
    end
    send_frame("post", 8'h02, 2'd2);

    // 6a: DIV=5, 181 mod 5 = 1.
    load5 = 1'b1;
    din5  = 8'hB5;
    step();
    load5 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("d5_bit", x_out5, 8'hB5 >> (7 - k) & 8'h01);
      step();
    end
    check("d5_done", done5, 1'b1);
    check("d5_rem",  rem_out5, 3'd1);

    // 6b: WIDTH=1, din=1 -> one bit, done in cycle 2, rem 1.
    load1 = 1'b1;
    din1  = 1'b1;
    step();
    load1 = 1'b0;
    check("w1_valid", x_valid1, 1'b1);
    check("w1_bit",   x_out1,   1'b1);
    check("w1_ready", ready1,   1'b0);
    step();
    check("w1_done",   done1,    1'b1);
    check("w1_rem",    rem_out1, 2'd1);
    check("w1_dvalid", x_valid1, 1'b0);
    step();
    check("w1_idle_done", done1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
